// File: rtl/alu_sel_pipe.sv
// ---------------------------------------------------------------------------
// alu_sel_pipe
//   Operand-select + ALU stage placed between the operand banks and the
//   display driver. One operand is picked from each NSRC-wide source bank.
//   The selected operation is executed either in a single EXEC cycle or as
//   a WIDTH-cycle shift-add multiply. The result and flags are returned over
//   a valid/ready pair.
//
// Parameters
//   WIDTH  operand/result width (>=2)
//   NSRC   sources per operand bank (>=2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         global enable; low freezes every register and blocks handshakes
//   a_bus      operand bank A, source k at [k*WIDTH +: WIDTH]
//   b_bus      operand bank B, same packing
//   sel_a      A source select (out-of-range selects source 0)
//   sel_b      B source select (out-of-range selects source 0)
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1,
//              110 CMPLT, 111 MUL
//   in_valid   request valid
//   in_ready   request accepted on an edge where in_valid & in_ready
//   out_valid  result/flags valid
//   out_ready  consumer takes the result on an edge where out_valid & out_ready
//   result     registered result
//   carry      carry / borrow / shift-out flag
//   zero       result == 0
//   ovf        signed overflow (ADD/SUB) or product overflow (MUL)
//   busy       high while in EXEC or MUL
// ---------------------------------------------------------------------------
module alu_sel_pipe #(
  parameter int WIDTH = 4,
  parameter int NSRC  = 4,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NSRC*WIDTH-1:0]  a_bus,
  input  logic [NSRC*WIDTH-1:0]  b_bus,
  input  logic [SEL_W-1:0]       sel_a,
  input  logic [SEL_W-1:0]       sel_b,
  input  logic [2:0]             op,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   carry,
  output logic                   zero,
  output logic                   ovf,
  output logic                   busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SHL1  = 3'b101,
    OP_CMPLT = 3'b110,
    OP_MUL   = 3'b111
  } op_t;

  state_t state, state_nx;

  logic                 accept;
  logic [WIDTH-1:0]     a_sel, b_sel;

  // Captured request
  logic [WIDTH-1:0]     opa, opb;
  logic [2:0]           op_r;

  // Single-cycle execution results
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     ex_res;
  logic                 ex_carry, ex_ovf;

  // Shift-add multiplier state
  logic [2*WIDTH-1:0]   acc, mcand, acc_nx;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  // -------------------------------------------------------------------------
  // Source selection: slot 0 is the default, so any select value that does
  // not name an existing source (possible when NSRC is not a power of two)
  // falls through to source 0.
  // -------------------------------------------------------------------------
  always_comb begin
    a_sel = a_bus[WIDTH-1:0];
    b_sel = b_bus[WIDTH-1:0];
    for (int unsigned k = 1; k < NSRC; k++) begin
      if (sel_a == SEL_W'(k)) a_sel = a_bus[k*WIDTH +: WIDTH];
      if (sel_b == SEL_W'(k)) b_sel = b_bus[k*WIDTH +: WIDTH];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (in_valid) state_nx = (op == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_DONE;
      end
      S_MUL: begin
        if (cnt == CNT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_nx = (op == OP_MUL) ? S_MUL : S_EXEC;
          else          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode (the only unregistered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = en & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    out_valid = en & (state == S_DONE);
    accept    = in_valid & in_ready;
  end

  // -------------------------------------------------------------------------
  // Single-cycle ALU on the captured operands
  // -------------------------------------------------------------------------
  always_comb begin
    sum      = {1'b0, opa} + {1'b0, opb};
    diff     = {1'b0, opa} - {1'b0, opb};
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    case (op_r)
      OP_ADD: begin
        ex_res   = sum[WIDTH-1:0];
        ex_carry = sum[WIDTH];
        ex_ovf   = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                   (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res   = diff[WIDTH-1:0];
        ex_carry = diff[WIDTH];            // borrow: A < B unsigned
        ex_ovf   = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                   (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:  ex_res = opa & opb;
      OP_OR:   ex_res = opa | opb;
      OP_XOR:  ex_res = opa ^ opb;
      OP_SHL1: begin
        ex_res   = {opa[WIDTH-2:0], 1'b0};
        ex_carry = opa[WIDTH-1];
      end
      OP_CMPLT: ex_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: begin
        ex_res   = '0;
        ex_carry = 1'b0;
        ex_ovf   = 1'b0;
      end
    endcase
  end

  // One multiplier bit per iteration; the final iteration's sum is written
  // straight to the outputs so the product appears on the same edge.
  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa    <= '0;
      opb    <= '0;
      op_r   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
    end else if (en) begin
      if (accept) begin
        opa    <= a_sel;
        opb    <= b_sel;
        op_r   <= op;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_sel};
        mplier <= b_sel;
        cnt    <= '0;
      end

      if (state == S_EXEC) begin
        result <= ex_res;
        carry  <= ex_carry;
        zero   <= (ex_res == '0);
        ovf    <= ex_ovf;
      end

      if (state == S_MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          result <= acc_nx[WIDTH-1:0];
          carry  <= 1'b0;
          zero   <= (acc_nx[WIDTH-1:0] == '0);
          ovf    <= |acc_nx[2*WIDTH-1:WIDTH];
        end
      end

      busy <= (state_nx == S_EXEC) || (state_nx == S_MUL);
    end
  end

endmodule

// File: tb/tb_alu_sel_pipe.sv
module tb_alu_sel_pipe;

  localparam int WIDTH = 4;
  localparam int NSRC  = 4;
  localparam int SEL_W = 2;
  localparam int BW    = NSRC * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [BW-1:0]    a_bus, b_bus;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic [2:0]       op;
  logic             in_valid, in_ready;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result;
  logic             carry, zero, ovf, busy;

  always #5 clk = ~clk;

  alu_sel_pipe #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_bus(a_bus), .b_bus(b_bus), .sel_a(sel_a), .sel_b(sel_b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .ovf(ovf), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Expected {result, carry, zero, ovf} and latency of the current request
  logic [WIDTH+2:0] exp_v;
  int               exp_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from plain integer arithmetic; returns {result,carry,zero,ovf}
  function automatic logic [WIDTH+2:0] ref_alu(input int a, input int b, input int o);
    int m, h, sa, sb, r, c, v;
    logic [WIDTH-1:0] rr;
    m  = 1 << WIDTH;
    h  = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r = 0; c = 0; v = 0;
    case (o)
      0: begin r = a + b; c = (r >= m); v = (sa + sb >= h) || (sa + sb < -h); r = r % m; end
      1: begin r = a - b; c = (a < b);  v = (sa - sb >= h) || (sa - sb < -h); if (r < 0) r = r + m; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % m; c = (a >= h); end
      6: r = (a < b) ? 1 : 0;
      default: begin r = a * b; v = (r >= m); r = r % m; end
    endcase
    rr = r[WIDTH-1:0];
    return {rr, c != 0, rr == '0, v != 0};
  endfunction

  task automatic load(input int av, input int bv, input int sa, input int sb, input int o);
    a_bus = BW'($urandom);
    b_bus = BW'($urandom);
    a_bus[sa*WIDTH +: WIDTH] = WIDTH'(av);
    b_bus[sb*WIDTH +: WIDTH] = WIDTH'(bv);
    sel_a = SEL_W'(sa);
    sel_b = SEL_W'(sb);
    op    = 3'(o);
    exp_v   = ref_alu(av, bv, o);
    exp_lat = (o == 7) ? WIDTH : 1;
  endtask

  // Present the loaded request and let it be accepted; operands are then
  // scrambled so only the captured copies can produce the right answer.
  task automatic accept(input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    a_bus = BW'($urandom);
    b_bus = BW'($urandom);
    sel_a = SEL_W'($urandom);
    sel_b = SEL_W'($urandom);
    op    = 3'($urandom);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_out(input string tag, input int lat_exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_lat"},    lat, lat_exp);
    check({tag, "_valid"},  out_valid, 1);
    check({tag, "_result"}, result, exp_v[WIDTH+2:3]);
    check({tag, "_carry"},  carry, exp_v[2]);
    check({tag, "_zero"},   zero,  exp_v[1]);
    check({tag, "_ovf"},    ovf,   exp_v[0]);
    check({tag, "_idle"},   busy,  0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_taken"}, out_valid, 0);
  endtask

  task automatic xact(input string tag, input int av, input int bv,
                      input int sa, input int sb, input int o);
    load(av, bv, sa, sb, o);
    accept(tag);
    wait_out(tag, exp_lat);
    consume(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH+2:0] held;
    int lat;

    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_bus = '0; b_bus = '0; sel_a = '0; sel_b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result",    result, 0);
    check("rst_carry",     carry, 0);
    check("rst_zero",      zero, 0);
    check("rst_ovf",       ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_in_ready",  in_ready, 1);
    rst = 1'b1;
    tick;

    // Directed operations
    xact("add",   9, 8, 2, 1, 0);
    xact("sub",   3, 5, 0, 3, 1);
    xact("subz",  7, 7, 1, 2, 1);
    xact("mul1",  3, 5, 3, 0, 7);
    xact("mul2",  6, 3, 2, 2, 7);
    xact("shl",  12, 0, 1, 1, 5);
    xact("lt",    2, 9, 0, 1, 6);
    xact("mulz",  0, 9, 3, 3, 7);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      xact("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)));
    end

    // Backpressure, then back-to-back accept on the draining edge
    load(5, 6, 1, 0, 0);
    accept("bp");
    wait_out("bp", exp_lat);
    held = exp_v;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_hold_valid",  out_valid, 1);
      check("bp_hold_result", {result, carry, zero, ovf}, held);
      check("bp_hold_rdy",    in_ready, 0);
    end
    load(10, 12, 3, 2, 4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_bus = BW'($urandom);
    b_bus = BW'($urandom);
    check("b2b_valid_low", out_valid, 0);
    check("b2b_busy",      busy, 1);
    wait_out("b2b", 1);
    consume("b2b");

    // Reset during a multiply aborts it
    load(7, 7, 0, 1, 7);
    accept("rstm");
    tick;
    tick;
    #2 rst = 1'b0;
    #1;
    check("rstm_valid",  out_valid, 0);
    check("rstm_busy",   busy, 0);
    check("rstm_result", result, 0);
    check("rstm_rdy",    in_ready, 1);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rstm_quiet", out_valid, 0);
    end
    xact("post_rst", 11, 4, 2, 3, 1);

    // Enable freeze mid-multiply adds exactly the frozen cycles
    load(5, 3, 1, 1, 7);
    accept("en");
    lat = 0;
    tick;
    lat++;
    en = 1'b0;
    #1;
    check("en_rdy_low", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      lat++;
      check("en_busy_hold", busy, 1);
      check("en_no_valid",  out_valid, 0);
    end
    en = 1'b1;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    check("en_lat",    lat, WIDTH + 3);
    check("en_result", result, exp_v[WIDTH+2:3]);
    check("en_ovf",    ovf, exp_v[0]);
    en = 1'b0;
    #1;
    check("en_done_gate", out_valid, 0);
    en = 1'b1;
    #1;
    check("en_done_back", out_valid, 1);
    consume("en");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
